longdiv_arbiter: RTL

- Shares one bit-serial restoring divider between two independent requesters.
- Sequences each division through an internal load/iterate/done state machine.
- Uses round-robin arbitration with valid/ready handshakes on both request ports and on the single response port.
- Sits between the filter-control logic and the divider datapath; returns quotient, remainder, requester ID and a divide-by-zero flag.

---
 rtl/longdiv_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/longdiv_arbiter.sv
// Round-robin arbiter sharing one bit-serial restoring divider between two requesters.
// Optional macro LONGDIV_ARB_PERF_EN adds saturating per-requester response counters.
module longdiv_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_dividend,
  input  logic [DATA_W-1:0] i_req0_divisor,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_dividend,
  input  logic [DATA_W-1:0] i_req1_divisor,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_quotient,
  output logic [DATA_W-1:0] o_rsp_remainder,
  output logic              o_rsp_id,
  output logic              o_rsp_div_by_zero,
`ifdef LONGDIV_ARB_PERF_EN
  output logic [15:0]       o_perf_cnt0,
  output logic [15:0]       o_perf_cnt1,
`endif
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic              rr_ptr;
  logic [DATA_W-1:0] dvd_q, dvs_q, quo_q, rem_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              id_q, dbz_q;

  logic              take0, take1, accept, acc_id;
  logic [DATA_W-1:0] acc_dvd, acc_dvs;
  logic [DATA_W:0]   rem_shift, rem_sub;
  logic              rsp_fire;

  // Grant only in IDLE; the pointer breaks ties when both requesters are valid.
  always_comb begin
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    if (state == IDLE) begin
      if (i_req0_valid && i_req1_valid) begin
        o_req0_ready = ~rr_ptr;
        o_req1_ready = rr_ptr;
      end else begin
        o_req0_ready = i_req0_valid;
        o_req1_ready = i_req1_valid;
      end
    end
  end

  assign take0     = i_req0_valid & o_req0_ready;
  assign take1     = i_req1_valid & o_req1_ready;
  assign accept    = take0 | take1;
  assign acc_id    = take1;
  assign acc_dvd   = take1 ? i_req1_dividend : i_req0_dividend;
  assign acc_dvs   = take1 ? i_req1_divisor  : i_req0_divisor;
  assign rem_shift = {rem_q, dvd_q[DATA_W-1]};
  assign rem_sub   = rem_shift - {1'b0, dvs_q};
  assign rsp_fire  = (state == DONE) && i_rsp_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (acc_dvs == '0) ? DONE : ITER;
      ITER: if (cnt_q == CNT_W'(DATA_W - 1)) state_nxt = DONE;
      DONE: if (i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr_ptr <= 1'b0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      id_q   <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            id_q   <= acc_id;
            rr_ptr <= ~acc_id;
            dvs_q  <= acc_dvs;
            dvd_q  <= acc_dvd;
            cnt_q  <= '0;
            // A zero divisor skips iteration and reports saturated quotient.
            if (acc_dvs == '0) begin
              quo_q <= '1;
              rem_q <= acc_dvd;
              dbz_q <= 1'b1;
            end else begin
              quo_q <= '0;
              rem_q <= '0;
              dbz_q <= 1'b0;
            end
          end
        end
        ITER: begin
          dvd_q <= {dvd_q[DATA_W-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
          if (rem_shift >= {1'b0, dvs_q}) begin
            rem_q <= rem_sub[DATA_W-1:0];
            quo_q <= {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_q <= rem_shift[DATA_W-1:0];
            quo_q <= {quo_q[DATA_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_valid       = (state == DONE);
  assign o_busy            = (state != IDLE);
  assign o_rsp_quotient    = quo_q;
  assign o_rsp_remainder   = rem_q;
  assign o_rsp_id          = id_q;
  assign o_rsp_div_by_zero = dbz_q;

`ifdef LONGDIV_ARB_PERF_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_perf_cnt0 <= '0;
      o_perf_cnt1 <= '0;
    end else if (rsp_fire) begin
      if (!id_q && o_perf_cnt0 != 16'hFFFF) o_perf_cnt0 <= o_perf_cnt0 + 16'd1;
      if (id_q && o_perf_cnt1 != 16'hFFFF)  o_perf_cnt1 <= o_perf_cnt1 + 16'd1;
    end
  end
`else
  logic unused_fire;
  assign unused_fire = rsp_fire;
`endif

endmodule
